// File: rtl/cpu_pkg.sv
// Shared definitions for the MEM stage: FSM encoding and control-bit positions
// inside the EX/MEM control bundles.
package cpu_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // Bit positions within wb_in / wb_out
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  // Bit positions within mem_in
  localparam int MEM_BRANCH = 2;
  localparam int MEM_READ   = 1;
  localparam int MEM_WRITE  = 0;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge port. The stage is the master; the memory
// (or its model) is the slave. Read data is only meaningful while ack is high.
interface mem_stage_if #(
  parameter int AW = 32
);
  logic          dmem_req;
  logic          dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [31:0]   dmem_wdata;
  logic [31:0]   dmem_rdata;
  logic          dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_stage_mem_to_wb.sv
// MEM/WB pipeline register. A bubble zeroes only the write-back control so the
// register file is left untouched; the data fields simply hold.
module mem_to_wb
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        bubble,
  input  logic [1:0]  wb_d,
  input  logic [31:0] readdata_d,
  input  logic [31:0] alu_result_d,
  input  logic [4:0]  wb_address_d,
  output logic [1:0]  wb_out,
  output logic [31:0] readdata_out,
  output logic [31:0] alu_result_out,
  output logic [4:0]  wb_address_out
);

  // Register update with synchronous active-low clear and bubble insert
  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_out         <= '0;
      readdata_out   <= '0;
      alu_result_out <= '0;
      wb_address_out <= '0;
    end else if (bubble) begin
      wb_out <= '0;
    end else begin
      wb_out         <= wb_d;
      readdata_out   <= readdata_d;
      alu_result_out <= alu_result_d;
      wb_address_out <= wb_address_d;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: branch resolution, variable-latency load/store through a
// req/ack port with timeout abort, stall generation and the MEM/WB register.
module mem_stage
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int AW      = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  wb_in,
  input  logic [2:0]  mem_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] writedata_in,
  input  logic        zero_in,
  input  logic [4:0]  wb_address_in,
  mem_stage_if.master mem_if,
  output logic        pc_src,
  output logic [31:0] branch_target,
  output logic        stall,
  output logic [1:0]  wb_out,
  output logic [31:0] readdata_out,
  output logic [31:0] alu_result_out,
  output logic [4:0]  wb_address_out,
  output logic        err_timeout,
  output logic        err_misalign
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state, state_n;
  logic [CW-1:0] counter, counter_n;
  logic          mem_op, access, misaligned;
  logic          ack_done, to_done;
  logic [1:0]    wb_d;
  logic [31:0]   readdata_d;

  assign mem_op     = mem_in[MEM_READ] | mem_in[MEM_WRITE];
  assign access     = mem_op & (alu_result_in[1:0] == 2'b00);
  assign misaligned = mem_op & (alu_result_in[1:0] != 2'b00);

  assign ack_done = (state == ACCESS) & mem_if.dmem_ack;
  assign to_done  = (state == ACCESS) & ~mem_if.dmem_ack & (counter == CNT_LAST);

  assign pc_src        = mem_in[MEM_BRANCH] & zero_in;
  assign branch_target = pc_in;

  assign mem_if.dmem_req   = (state == ACCESS);
  assign mem_if.dmem_we    = mem_in[MEM_WRITE];
  assign mem_if.dmem_addr  = AW'(alu_result_in);
  assign mem_if.dmem_wdata = writedata_in;

  assign stall = ((state == IDLE) & access)
               | ((state == ACCESS) & ~mem_if.dmem_ack & (counter != CNT_LAST));

  // FSM state, timeout counter and sticky error flags
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      counter      <= '0;
      err_timeout  <= 1'b0;
      err_misalign <= 1'b0;
    end else begin
      state   <= state_n;
      counter <= counter_n;
      if (to_done)
        err_timeout <= 1'b1;
      if ((state == IDLE) && misaligned)
        err_misalign <= 1'b1;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_n   = state;
    counter_n = counter;
    case (state)
      IDLE: begin
        if (access) begin
          state_n   = ACCESS;
          counter_n = '0;
        end
      end
      ACCESS: begin
        if (ack_done || to_done)
          state_n = IDLE;
        else
          counter_n = counter + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // MEM/WB next values: cancel write-back on timeout or misalignment
  always_comb begin
    wb_d       = wb_in;
    readdata_d = '0;
    if (ack_done) begin
      if (mem_in[MEM_READ])
        readdata_d = mem_if.dmem_rdata;
    end else if (to_done) begin
      wb_d = '0;
    end else if ((state == IDLE) && misaligned) begin
      wb_d = '0;
    end
  end

  mem_to_wb u_mem_to_wb (
    .clk            (clk),
    .rst            (rst),
    .bubble         (stall),
    .wb_d           (wb_d),
    .readdata_d     (readdata_d),
    .alu_result_d   (alu_result_in),
    .wb_address_d   (wb_address_in),
    .wb_out         (wb_out),
    .readdata_out   (readdata_out),
    .alu_result_out (alu_result_out),
    .wb_address_out (wb_address_out)
  );

endmodule
